// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   DIGIT_W            : width of one requester value (four hex digits)
//   sseg_sched_state_e : scheduler FSM states (IDLE, SHOW)
package sseg_pkg;

  localparam int DIGIT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sseg_sched_state_e;

endpackage

// File: rtl/sseg_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req_i at or after index ptr_i, wrapping
// modulo NUM_REQ.
//   req_i   : request vector
//   ptr_i   : search start index
//   pick_o  : one-hot selected requester (all-zero when none)
//   found_o : high when any request was found
module sseg_rr_pick
  import sseg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               found_o
);

  always_comb begin
    logic [PTR_W:0] sum;
    pick_o  = '0;
    found_o = 1'b0;
    sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // One spare bit keeps ptr + i from overflowing before the wrap.
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!found_o && req_i[sum[PTR_W-1:0]]) begin
        pick_o[sum[PTR_W-1:0]] = 1'b1;
        found_o                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_sched.sv
// Time-sliced scheduler sharing one 4-digit seven-segment display among
// NUM_REQ requesters. Grants round-robin with a minimum hold of
// HOLD_CYCLES cycles and drives the digits bus of the sseg multiplexer.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester level-sensitive display request
//   data     : requester i value at [16i+15:16i]
//   blink    : per-requester blink enable (blink build only)
//   grant    : one-hot display owner, zero when idle
//   digits   : value to the sseg digits input
//   blank    : display blank request
//   busy     : high while a requester owns the display
// Optional feature: define SSEG_SCHED_BLINK_EN to build the blink phase
// counter; otherwise blank is tied low and blink is ignored.
module sseg_sched
  import sseg_pkg::*;
#(
  parameter int                 NUM_REQ      = 4,
  parameter int                 HOLD_CYCLES  = 50_000_000,
  parameter int                 BLINK_CYCLES = 25_000_000,
  parameter logic [DIGIT_W-1:0] IDLE_DIGITS  = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DIGIT_W-1:0] data,
  input  logic [NUM_REQ-1:0]         blink,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DIGIT_W-1:0]         digits,
  output logic                       blank,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  sseg_sched_state_e   state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DIGIT_W-1:0]  digits_q, digits_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                grant_chg;

  logic [DIGIT_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  pick;
  logic                found;
  logic [PTR_W-1:0]    pick_ptr;
  logic [PTR_W-1:0]    pick_idx;
  logic                expire;
  logic                others;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_REQ - 1)) return '0;
    return idx + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = data[g*DIGIT_W +: DIGIT_W];
  end

  // While showing, the next owner is searched from owner+1 so the current
  // owner is considered last; in IDLE the stored pointer is used.
  assign pick_ptr = (state_q == SHOW) ? next_idx(owner_q) : ptr_q;
  assign expire   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign others   = |(req & ~grant_q);

  sseg_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .pick_o  (pick),
    .found_o (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_chg = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = SHOW;
          grant_d   = pick;
          owner_d   = pick_idx;
          digits_d  = data_arr[pick_idx];
          cnt_d     = '0;
          grant_chg = 1'b1;
        end
      end
      SHOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Track live data only while the owner still requests; otherwise
        // the last sampled value stays frozen on the display.
        if (req[owner_q]) digits_d = data_arr[owner_q];
        if (expire) begin
          if (others) begin
            ptr_d     = next_idx(owner_q);
            grant_d   = pick;
            owner_d   = pick_idx;
            digits_d  = data_arr[pick_idx];
            cnt_d     = '0;
            grant_chg = 1'b1;
          end else if (req[owner_q]) begin
            cnt_d = '0;
          end else begin
            state_d   = IDLE;
            grant_d   = '0;
            digits_d  = IDLE_DIGITS;
            cnt_d     = '0;
            ptr_d     = next_idx(owner_q);
            grant_chg = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      digits_q <= IDLE_DIGITS;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign grant  = grant_q;
  assign digits = digits_q;
  assign busy   = (state_q == SHOW);

`ifdef SSEG_SCHED_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blank_q, blank_d;

  // Phase restarts low on every ownership change; it only advances while
  // the current owner asks for blinking.
  always_comb begin
    bcnt_d  = bcnt_q;
    blank_d = blank_q;
    if (grant_chg || (state_q == IDLE)) begin
      bcnt_d  = '0;
      blank_d = 1'b0;
    end else if (blink[owner_q]) begin
      if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
        bcnt_d  = '0;
        blank_d = ~blank_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  localparam int unused_blink_cycles = BLINK_CYCLES;
  logic unused_blink;
  assign unused_blink = ^{blink, grant_chg};
  assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_sched.sv
// Directed self-checking bench for sseg_sched with NUM_REQ=4,
// HOLD_CYCLES=8, BLINK_CYCLES=4, IDLE_DIGITS=0.
module tb_sseg_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  blink;
  logic [3:0]  grant;
  logic [15:0] digits;
  logic        blank;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  sseg_sched #(
    .NUM_REQ      (4),
    .HOLD_CYCLES  (8),
    .BLINK_CYCLES (4),
    .IDLE_DIGITS  (16'h0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .blink  (blink),
    .grant  (grant),
    .digits (digits),
    .blank  (blank),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    data[16*i +: 16] = v;
  endtask

  logic [15:0] rr_val [4];
  logic        exp_blank;

  initial begin
    rr_val[0] = 16'h1234;
    rr_val[1] = 16'h5678;
    rr_val[2] = 16'h9ABC;
    rr_val[3] = 16'hDEF0;
    rst   = 1'b1;
    req   = 4'b1111;
    blink = 4'b0000;
    data  = '0;
    for (int i = 0; i < 4; i++) set_data(i, rr_val[i]);

    // Reset held three cycles while everyone requests
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_grant", grant, 4'b0000);
      check("rst_digits", digits, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_blank", blank, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("rel_grant", grant, 4'b0001);

    // Round-robin: 0001,0010,0100,1000,0001 for 8 cycles each, no gap
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        check("rr_grant", grant, 4'b0001 << (k % 4));
        check("rr_digits", digits, rr_val[k % 4]);
        check("rr_busy", busy, 1'b1);
        tick();
      end
    end
    check("rr_wrap_next", grant, 4'b0010);

    rst = 1'b1;
    tick();
    check("rr_rst_grant", grant, 4'b0000);
    rst = 1'b0;
    req = 4'b0000;
    tick();
    check("idle_grant", grant, 4'b0000);
    check("idle_busy", busy, 1'b0);

    // Single requester kept across three expiries
    req = 4'b0100;
    set_data(2, 16'h8320);
    tick();
    check("single_grant", grant, 4'b0100);
    check("single_digits", digits, 16'h8320);
    for (int c = 0; c < 26; c++) begin
      tick();
      check("single_keep", grant, 4'b0100);
      check("single_busy", busy, 1'b1);
    end
    // Hold counter is now 2; drop the request and run out the hold
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("single_drop_hold", grant, 4'b0100);
      check("single_drop_dig", digits, 16'h8320);
    end
    tick();
    check("single_idle_grant", grant, 4'b0000);
    check("single_idle_dig", digits, 16'h0000);
    check("single_idle_busy", busy, 1'b0);

    // Early drop: requester 1 freezes ABCD until expiry (pointer is 3)
    set_data(1, 16'hABCD);
    req = 4'b0010;
    tick();
    check("early_grant", grant, 4'b0010);
    check("early_digits", digits, 16'hABCD);
    tick();
    tick();
    req = 4'b0000;
    set_data(1, 16'hFFFF);
    for (int c = 3; c < 8; c++) begin
      tick();
      check("early_freeze", digits, 16'hABCD);
      check("early_hold", grant, 4'b0010);
    end
    tick();
    check("early_idle_dig", digits, 16'h0000);
    check("early_idle_grant", grant, 4'b0000);

    // Live update then reset mid-hold
    set_data(0, 16'h1111);
    req = 4'b0001;
    tick();
    check("live_grant", grant, 4'b0001);
    check("live_digits0", digits, 16'h1111);
    tick();
    tick();
    tick();
    set_data(0, 16'h2222);
    tick();
    check("live_digits1", digits, 16'h2222);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_digits", digits, 16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_blank", blank, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_grant", grant, 4'b0001);
    check("post_rst_digits", digits, 16'h2222);

    // Blink phase on owner 0, then hand-off to owner 1 (no blink)
    rst   = 1'b1;
    req   = 4'b0011;
    blink = 4'b0001;
    tick();
    rst = 1'b0;
    tick();
    check("blink_grant0", grant, 4'b0001);
    for (int c = 0; c < 8; c++) begin
`ifdef SSEG_SCHED_BLINK_EN
      exp_blank = (c >= 4);
`else
      exp_blank = 1'b0;
`endif
      check("blink_phase", blank, exp_blank);
      tick();
    end
    check("blink_grant1", grant, 4'b0010);
    check("blink_clear", blank, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("blink_off", blank, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
